// File: rtl/boot_selector_pkg.sv
// Shared state encoding and image-advance helper for the warmboot image selector.
package boot_selector_pkg;

    localparam logic [2:0] ST_START    = 3'd0;
    localparam logic [2:0] ST_WAIT_REL = 3'd1;
    localparam logic [2:0] ST_SEL      = 3'd2;
    localparam logic [2:0] ST_PRESS    = 3'd3;
    localparam logic [2:0] ST_SEL_WAIT = 3'd4;
    localparam logic [2:0] ST_LOCK     = 3'd5;
    localparam logic [2:0] ST_BOOT     = 3'd6;

    // Cycling skips images below first_sel (image 0 is the stub itself).
    function automatic int next_img(input int sel, input int first_sel, input int n_images);
        return (sel == n_images - 1) ? first_sel : sel + 1;
    endfunction

endpackage

// File: rtl/boot_timer.sv
// Saturating cycle counter with synchronous clear and a compare-to-limit strobe.
module boot_timer #(
    parameter int TIMER_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [TIMER_W-1:0] limit,
    output logic [TIMER_W-1:0] count,
    output logic               hit
);

    logic [TIMER_W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (clr)
            count_nxt = '0;
        else if (en && (count != '1))
            count_nxt = count + TIMER_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else
            count <= count_nxt;
    end

    assign hit = (count == limit);

endmodule

// File: rtl/boot_selector.sv
// Button-driven warmboot image selector: picks an image, optionally locks flash,
// then raises a sticky boot request for SB_WARMBOOT.
module boot_selector
    import boot_selector_pkg::*;
#(
    parameter int N_IMAGES    = 4,
    parameter int FIRST_SEL   = 1,
    parameter int DEFAULT_IMG = 2,
    parameter int DFU_IMG     = 1,
    parameter int TIMEOUT_CYC = 12582912,
    parameter int REARM_CYC   = 131072,
    parameter int LONG_CYC    = 6291456,
    parameter int TIMER_W     = 24,
    parameter int LOCK_EN     = 1,
    parameter logic [N_IMAGES-1:0] LOCK_MASK = 4'b0110,
    localparam int SEL_W      = (N_IMAGES < 2) ? 1 : $clog2(N_IMAGES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_v,
    input  logic             btn_r,
    input  logic             btn_f,
    output logic             fl_go,
    input  logic             fl_rdy,
    output logic [SEL_W-1:0] boot_sel,
    output logic             boot_now,
    output logic             sel_mode,
    output logic             long_armed
);

    localparam int HALF_LONG = LONG_CYC / 2;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [2:0]         commit_state;
    logic [SEL_W-1:0]   sel_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] hold;
    logic [TIMER_W-1:0] hold_nxt;
    logic [TIMER_W-1:0] timer_limit;
    logic               timer_hit;
    logic               hold_hit;
    logic               timer_clr;
    logic               timer_en;
    logic               unused_timer_bits;

    assign commit_state = ((LOCK_EN != 0) && LOCK_MASK[boot_sel]) ? ST_LOCK : ST_BOOT;

    always_comb begin
        state_nxt = state;
        sel_nxt   = boot_sel;
        case (state)
            ST_START: begin
                if (btn_v) begin
                    state_nxt = commit_state;
                end else begin
                    state_nxt = ST_WAIT_REL;
                    sel_nxt   = SEL_W'(DFU_IMG);
                end
            end
            ST_WAIT_REL: begin
                if (btn_v)
                    state_nxt = ST_SEL_WAIT;
            end
            ST_SEL_WAIT: begin
                if (btn_v && timer_hit)
                    state_nxt = ST_SEL;
            end
            ST_SEL: begin
                if (btn_f)
                    state_nxt = ST_PRESS;
                else if (timer_hit)
                    state_nxt = commit_state;
            end
            ST_PRESS: begin
                // A release on the very cycle the hold matures still counts as short.
                if (btn_r) begin
                    sel_nxt   = SEL_W'(next_img(int'(boot_sel), FIRST_SEL, N_IMAGES));
                    state_nxt = ST_SEL_WAIT;
                end else if (hold_hit && !btn_v) begin
                    state_nxt = commit_state;
                end
            end
            ST_LOCK: begin
                // fl_go is high only in the first LOCK cycle, which masks a stale fl_rdy.
                if (!fl_go && fl_rdy)
                    state_nxt = ST_BOOT;
            end
            ST_BOOT: begin
                state_nxt = ST_BOOT;
            end
            default: begin
                state_nxt = ST_START;
            end
        endcase
    end

    assign timer_limit = (state == ST_SEL) ? TIMER_W'(TIMEOUT_CYC - 1) : TIMER_W'(REARM_CYC - 1);
    assign timer_clr   = (state_nxt != state) || ((state == ST_SEL_WAIT) && !btn_v);
    assign timer_en    = (state == ST_SEL) || (state == ST_SEL_WAIT);

    boot_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .limit (timer_limit),
        .count (timer),
        .hit   (timer_hit)
    );

    boot_timer #(.TIMER_W(TIMER_W)) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != ST_PRESS),
        .en    (1'b1),
        .limit (TIMER_W'(LONG_CYC - 1)),
        .count (hold),
        .hit   (hold_hit)
    );

    assign unused_timer_bits = ^timer;

    // Mirror of the hold counter's next value, so long_armed lines up with hold.
    always_comb begin
        hold_nxt = '0;
        if (state == ST_PRESS)
            hold_nxt = (hold == '1) ? hold : hold + TIMER_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_START;
            boot_sel   <= SEL_W'(DEFAULT_IMG);
            boot_now   <= 1'b0;
            fl_go      <= 1'b0;
            sel_mode   <= 1'b0;
            long_armed <= 1'b0;
        end else begin
            state      <= state_nxt;
            boot_sel   <= sel_nxt;
            boot_now   <= boot_now || (state == ST_BOOT);
            fl_go      <= (state_nxt == ST_LOCK) && (state != ST_LOCK);
            sel_mode   <= (state_nxt == ST_WAIT_REL) || (state_nxt == ST_SEL) ||
                          (state_nxt == ST_PRESS)    || (state_nxt == ST_SEL_WAIT);
            long_armed <= (state_nxt == ST_PRESS) && (hold_nxt >= TIMER_W'(HALF_LONG));
        end
    end

endmodule

// File: tb/tb_boot_selector.sv
// Directed bench for boot_selector with short timeouts; expected values are hand-derived.
module tb_boot_selector;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       btn_v  = 1'b1;
    logic       btn_r  = 1'b0;
    logic       btn_f  = 1'b0;
    logic       fl_rdy = 1'b0;
    logic       fl_go;
    logic       boot_now;
    logic       sel_mode;
    logic       long_armed;
    logic [1:0] boot_sel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    boot_selector #(
        .N_IMAGES    (4),
        .FIRST_SEL   (1),
        .DEFAULT_IMG (2),
        .DFU_IMG     (1),
        .TIMEOUT_CYC (100),
        .REARM_CYC   (10),
        .LONG_CYC    (50),
        .TIMER_W     (8),
        .LOCK_EN     (1),
        .LOCK_MASK   (4'b0110)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_v      (btn_v),
        .btn_r      (btn_r),
        .btn_f      (btn_f),
        .fl_go      (fl_go),
        .fl_rdy     (fl_rdy),
        .boot_sel   (boot_sel),
        .boot_now   (boot_now),
        .sel_mode   (sel_mode),
        .long_armed (long_armed)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic r, input logic f);
        btn_v = v;
        btn_r = r;
        btn_f = f;
    endtask

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkSel(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [1:0] sel, input logic now,
                            input logic go, input logic mode, input logic armed);
        checkSel({tag, ".boot_sel"}, boot_sel, sel);
        checkOutput({tag, ".boot_now"}, boot_now, now);
        checkOutput({tag, ".fl_go"}, fl_go, go);
        checkOutput({tag, ".sel_mode"}, sel_mode, mode);
        checkOutput({tag, ".long_armed"}, long_armed, armed);
    endtask

    // Asynchronous reset pulse released mid-cycle; returns just after the first active edge.
    task automatic doReset(input logic v);
        rst_n  = 1'b0;
        fl_rdy = 1'b0;
        applyStimulus(v, 1'b0, 1'b0);
        #2;
        checkAll("reset", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_release.fl_go", fl_go, 1'b0);
        tick();
    endtask

    // Power up with the button held and walk through re-arming into SEL (timer = 0).
    task automatic enterSel();
        doReset(1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(10);
    endtask

    // Press for len cycles and release; returns in the first SEL_WAIT cycle.
    task automatic shortPress(input int len);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(len - 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1;

        // Released at power-up: default image 2 is locked, then booted.
        doReset(1'b1);
        checkAll("s1_lock", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkAll("s1_lock_wait", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        fl_rdy = 1'b1;
        tick();
        fl_rdy = 1'b0;
        checkAll("s1_boot_state", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkAll("s1_boot_now", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("s1_boot_held", boot_now, 1'b1);

        // Held at power-up: DFU image, re-arm, idle timeout, lock with stale fl_rdy.
        doReset(1'b0);
        checkAll("s2_wait_rel", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(18);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(109);
        checkAll("s2_sel_last", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkAll("s2_lock", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        fl_rdy = 1'b1;
        tick();
        checkAll("s2_rdy_ignored", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("s2_boot_state", boot_now, 1'b0);
        tick();
        checkOutput("s2_boot_now", boot_now, 1'b1);
        fl_rdy = 1'b0;

        // Three short presses cycle 2, 3 and wrap to 1, then time out into LOCK.
        enterSel();
        checkAll("s3_sel", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        shortPress(10);
        checkAll("s3_press1", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(10);
        shortPress(10);
        checkSel("s3_press2", boot_sel, 2'd3);
        tick(10);
        shortPress(10);
        checkSel("s3_press3_wrap", boot_sel, 2'd1);
        tick(10);
        tick(99);
        checkOutput("s3_before_timeout", fl_go, 1'b0);
        tick();
        checkAll("s3_timeout_lock", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset while in LOCK, then restart from START with the button released.
        doReset(1'b1);
        checkAll("s6_restart", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);

        // Advance to image 3 and long-press: commits 3 straight to BOOT.
        enterSel();
        shortPress(10);
        tick(10);
        shortPress(10);
        tick(10);
        checkSel("s4_sel3", boot_sel, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("s4_hold0", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(24);
        checkOutput("s4_hold24_armed", long_armed, 1'b0);
        tick();
        checkOutput("s4_hold25_armed", long_armed, 1'b1);
        tick(24);
        checkAll("s4_hold49", 2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkAll("s4_boot_state", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkAll("s4_boot_now", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        // Release coincident with hold maturity, then press coincident with timeout.
        enterSel();
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(49);
        checkOutput("s5_hold49_armed", long_armed, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkAll("s5_release_wins", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(10);
        tick(99);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("s5_press_wins", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(2);
        checkAll("s5_no_commit", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkSel("s5_press_advanced", boot_sel, 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
